// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Latency: lookup is combinational (0 cycles); an update becomes visible after the next rising edge.
// Backpressure: none; one update is accepted every cycle and there is no ready signal.
module bpred_btb #(
  parameter int ENTRIES  = 16,
  parameter int AW       = 32,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [AW-1:0]    pred_next_pc,
  input  logic             flush_all,
  input  logic             upd_valid,
  input  logic [AW-1:0]    upd_pc,
  input  logic             upd_taken,
  input  logic [AW-1:0]    upd_target,
  input  logic             upd_pred_taken,
  input  logic [AW-1:0]    upd_pred_target,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = AW - IDXW - 2;

  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  // Freshly allocated entries start weakly taken: only the counter MSB set.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_ONE << (CTR_BITS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

  // Valid bits live outside the struct so flush can clear them in one shot.
  typedef struct packed {
    logic [TAGW-1:0]     tag;
    logic [AW-1:0]       target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  logic [ENTRIES-1:0] valid_q;
  entry_t             tbl_q [ENTRIES];

  logic [IDXW-1:0]     if_idx;
  logic [IDXW-1:0]     upd_idx;
  logic [TAGW-1:0]     if_tag;
  logic [TAGW-1:0]     upd_tag;
  entry_t              if_ent;
  entry_t              upd_ent;
  logic                upd_hit;
  logic                mispred;
  logic [CTR_BITS-1:0] ctr_inc;
  logic [CTR_BITS-1:0] ctr_dec;

  // PCs are word aligned, so the two LSBs carry no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{if_pc[1:0], upd_pc[1:0]};

  assign if_idx  = if_pc[IDXW+1:2];
  assign if_tag  = if_pc[AW-1:IDXW+2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[AW-1:IDXW+2];
  assign if_ent  = tbl_q[if_idx];
  assign upd_ent = tbl_q[upd_idx];

  // Fetch-side lookup straight off the array, so same-cycle updates are not seen.
  always_comb begin
    pred_hit     = valid_q[if_idx] && (if_ent.tag == if_tag);
    pred_taken   = pred_hit && if_ent.ctr[CTR_BITS-1];
    pred_next_pc = pred_taken ? if_ent.target : (if_pc + AW'(4));
  end

  // Resolve-side hit test, saturating counter steps and mispredict detection.
  always_comb begin
    upd_hit = valid_q[upd_idx] && (upd_ent.tag == upd_tag);
    ctr_inc = (upd_ent.ctr == CTR_MAX) ? CTR_MAX : (upd_ent.ctr + CTR_ONE);
    ctr_dec = (upd_ent.ctr == '0) ? '0 : (upd_ent.ctr - CTR_ONE);
    mispred = (upd_taken != upd_pred_taken) ||
              (upd_taken && (upd_pred_target != upd_target));
  end

  // Table write: flush wins over an update; not-taken misses never allocate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          tbl_q[upd_idx].ctr    <= ctr_inc;
          tbl_q[upd_idx].target <= upd_target;
        end else begin
          tbl_q[upd_idx].ctr <= ctr_dec;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        tbl_q[upd_idx]   <= '{tag: upd_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

  // Saturating mispredict counter; counts even while the table is being flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispred_cnt <= '0;
    end else if (upd_valid && mispred && (mispred_cnt != CNT_MAX)) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Self-checking bench for bpred_btb with ENTRIES=16, AW=32, CTR_BITS=2, CNT_W=16.
// A table-of-records model predicts every output at each falling edge.
// Directed scenarios pin the model with literal expectations, then random traffic runs.
module tb_bpred_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        flush_all;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic [15:0] mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one record per slot, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_cnt;

  bpred_btb #(.ENTRIES(16), .AW(32), .CTR_BITS(2), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .flush_all       (flush_all),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_lookup(input logic [31:0] pc, output bit hit,
                                       output bit tk, output logic [31:0] nxt);
    int idx;
    idx = int'(pc[5:2]);
    hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
    tk  = hit && (m_ctr[idx] >= 2);
    nxt = tk ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_update();
    bit          hit;
    bit          tk;
    logic [31:0] nxt;
    int          idx;
    if (upd_valid) begin
      if ((upd_taken != upd_pred_taken) || (upd_taken && (upd_pred_target != upd_target)))
        if (m_cnt < 65535) m_cnt++;
    end
    if (flush_all) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (upd_valid) begin
      model_lookup(upd_pc, hit, tk, nxt);
      idx = int'(upd_pc[5:2]);
      if (hit && upd_taken) begin
        m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        m_tgt[idx] = upd_target;
      end else if (hit) begin
        m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end else if (upd_taken) begin
        m_valid[idx] = 1;
        m_tag[idx]   = upd_pc[31:6];
        m_tgt[idx]   = upd_target;
        m_ctr[idx]   = 2;
      end
    end
  endfunction

  initial model_reset();

  // Model state follows the same clock and asynchronous reset as the block.
  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_update();
  end

  // Every cycle, compare all outputs against the model away from the rising edge.
  always @(negedge clk) begin
    bit          e_hit;
    bit          e_tk;
    logic [31:0] e_nxt;
    model_lookup(if_pc, e_hit, e_tk, e_nxt);
    chk("cmp_hit",   32'(pred_hit),    32'(e_hit));
    chk("cmp_taken", 32'(pred_taken),  32'(e_tk));
    chk("cmp_next",  pred_next_pc,     e_nxt);
    chk("cmp_cnt",   32'(mispred_cnt), m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic expect_out(input string name, input bit hit, input bit tk,
                            input logic [31:0] nxt, input int cnt);
    chk({name, "_hit"},   32'(pred_hit),    32'(hit));
    chk({name, "_taken"}, 32'(pred_taken),  32'(tk));
    chk({name, "_next"},  pred_next_pc,     nxt);
    chk({name, "_cnt"},   32'(mispred_cnt), cnt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [25:0] tag;
    case ($urandom_range(0, 4))
      0:       tag = 26'd0;
      1:       tag = 26'd1;
      2:       tag = 26'd2;
      3:       tag = 26'd3;
      default: tag = '1;
    endcase
    return {tag, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    logic [31:0] t;
    reset     = 1'b0;
    flush_all = 1'b0;
    if_pc     = 32'h40;
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Held in reset: nothing hits, fall-through address, zero count.
    @(negedge clk);
    expect_out("reset", 0, 0, 32'h44, 0);
    reset = 1'b1;

    // First taken update allocates weakly-taken and counts a mispredict.
    set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("alloc", 1, 1, 32'h100, 1);

    // Not-taken walk: 2 -> 1 -> 0 -> 0.
    set_upd(1, 32'h40, 0, 32'h0, 1, 32'h100);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("nt1", 1, 0, 32'h44, 2);
    set_upd(1, 32'h40, 0, 32'h0, 0, 32'h44);
    tick();
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("nt3", 1, 0, 32'h44, 2);

    // If 0 held, one taken step leaves it not-taken and a second makes it taken.
    set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("sat0", 1, 0, 32'h44, 3);
    set_upd(1, 32'h40, 1, 32'h100, 0, 32'h44);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("retake", 1, 1, 32'h100, 4);

    // Alias at index 0 evicts 0x40.
    set_upd(1, 32'h80, 1, 32'h200, 0, 32'h84);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    if_pc = 32'h80;
    @(negedge clk);
    expect_out("alias_new", 1, 1, 32'h200, 5);
    tick();
    if_pc = 32'h40;
    @(negedge clk);
    expect_out("alias_old", 0, 0, 32'h44, 5);

    // Same-cycle lookup sees the entry before the update lands.
    tick();
    if_pc = 32'h80;
    set_upd(1, 32'h80, 0, 32'h0, 1, 32'h200);
    @(negedge clk);
    expect_out("same_cyc", 1, 1, 32'h200, 5);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("after_upd", 1, 0, 32'h84, 6);

    // Flush overrides a concurrent taken update, but the mispredict still counts.
    tick();
    flush_all = 1'b1;
    set_upd(1, 32'h40, 1, 32'h300, 0, 32'h44);
    tick();
    flush_all = 1'b0;
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    expect_out("flush80", 0, 0, 32'h84, 7);
    tick();
    if_pc = 32'h40;
    @(negedge clk);
    expect_out("flush40", 0, 0, 32'h44, 7);

    // Top-of-address-space fall-through wraps to zero.
    tick();
    if_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    expect_out("wrap", 0, 0, 32'h0, 7);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      tick();
      if_pc     = rand_pc();
      flush_all = ($urandom_range(0, 49) == 0);
      t         = $urandom();
      set_upd($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 1) == 1,
              t, $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? t : $urandom());
    end

    // Drive the mispredict counter to saturation and one past it.
    tick();
    flush_all = 1'b0;
    set_upd(1, 32'h1000_0040, 0, 32'h0, 1, 32'h0);
    for (int i = 0; i < 65536 && m_cnt < 65535; i++) tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("cnt_full", 32'(mispred_cnt), 32'hFFFF);
    set_upd(1, 32'h1000_0040, 0, 32'h0, 1, 32'h0);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("cnt_hold", 32'(mispred_cnt), 32'hFFFF);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    set_upd(1, 32'h40, 1, 32'h500, 1, 32'h500);
    tick();
    set_upd(0, 32'h0, 0, 32'h0, 0, 32'h0);
    if_pc = 32'h40;
    @(negedge clk);
    expect_out("pre_rst", 1, 1, 32'h500, 65535);
    tick();
    #2 reset = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 32'h44, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    tick();
    tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
